remap_sched: RTL and testbench

//  Shares one pipelined piecewise-linear m1->m2 remap evaluator among NREQ requesters (round-robin).

---
 rtl/remap_sched_pkg.sv | 26 ++
 rtl/remap_sched_if.sv | 27 ++
 rtl/remap_sched_rr_arb.sv | 29 ++
 rtl/remap_sched.sv | 95 +++++++++
 tb/tb_remap_sched.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/remap_sched_pkg.sv
// remap_sched_pkg: widths, table sizes, segment bounds, FSM/segment encodings and the per-segment adder
package remap_sched_pkg;
  localparam int M1_W = 23;
  localparam int M2_W = M1_W - 1;
  localparam int SEG1_NUM = 10;
  localparam int SEG2_NUM = 12;
  localparam int SEG3_NUM = 10;
  localparam int SEG4_NUM = 10;
  localparam int PIECE_NUM = SEG1_NUM + SEG2_NUM + SEG3_NUM + SEG4_NUM;
  localparam int NODE_NUM = PIECE_NUM + 1;
  localparam int SEG2_LO = SEG1_NUM;
  localparam int SEG3_LO = SEG2_LO + SEG2_NUM;
  localparam int SEG4_LO = SEG3_LO + SEG3_NUM;
  localparam int PW = $clog2(PIECE_NUM);
  localparam int AW = 6;
  localparam int NREQ = 4;
  localparam int ID_W = $clog2(NREQ);
  typedef enum logic [1:0] {ST_CFG, ST_RUN, ST_DRAIN} state_t;
  typedef enum logic [1:0] {SEG1, SEG2, SEG3, SEG4} seg_t;
  function automatic seg_t seg_of(input logic [PW-1:0] p);
    return int'(p) < SEG2_LO ? SEG1 : int'(p) < SEG3_LO ? SEG2 : int'(p) < SEG4_LO ? SEG3 : SEG4;
  endfunction
  function automatic logic [M1_W-1:0] adder_of(input seg_t s, input logic [M1_W-1:0] m1);
    return s == SEG1 ? m1 << 2 : s == SEG2 ? '0 : s == SEG3 ? -(m1 >> 3) : -(m1 >> 2);
  endfunction
endpackage

// File: rtl/remap_sched_if.sv
// remap_sched_if: config, request and response bundle between requesters and the remap scheduler
interface remap_sched_if;
  import remap_sched_pkg::*;
  logic cfg_req;
  logic cfg_ready;
  logic cfg_we;
  logic cfg_sel;
  logic [AW-1:0] cfg_addr;
  logic [M1_W-1:0] cfg_data;
  logic cfg_done;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*M1_W-1:0] req_m1;
  logic [NREQ-1:0] req_ready;
  logic rsp_valid;
  logic rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [M2_W-1:0] rsp_m2;
  logic rsp_oor;
  modport master (
    output cfg_req, cfg_we, cfg_sel, cfg_addr, cfg_data, cfg_done, req_valid, req_m1, rsp_ready,
    input cfg_ready, req_ready, rsp_valid, rsp_id, rsp_m2, rsp_oor
  );
  modport slave (
    input cfg_req, cfg_we, cfg_sel, cfg_addr, cfg_data, cfg_done, req_valid, req_m1, rsp_ready,
    output cfg_ready, req_ready, rsp_valid, rsp_id, rsp_m2, rsp_oor
  );
endinterface

// File: rtl/remap_sched_rr_arb.sv
// remap_rr_arb: round-robin one-hot arbiter; pointer moves to the winner whenever a grant is issued
module remap_rr_arb
  import remap_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [NREQ-1:0] valid_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] idx_o
);
  logic [ID_W-1:0] ptr_q;
  logic any;
  // scan downward in offset so the requester closest after the pointer overwrites last and wins
  always_comb begin
    idx_o = '0;
    any = 1'b0;
    for (int i = NREQ; i >= 1; i--)
      if (valid_i[ptr_q + ID_W'(i)]) begin
        idx_o = ptr_q + ID_W'(i);
        any = 1'b1;
      end
    gnt_o = (en_i && any) ? NREQ'(1) << idx_o : '0;
  end
  // a grant always lands on a valid requester, so every grant is a transfer
  always_ff @(posedge clk)
    if (rst) ptr_q <= ID_W'(NREQ - 1);
    else if (|gnt_o) ptr_q <= idx_o;
endmodule

// File: rtl/remap_sched.sv
// remap_sched: round-robin shared two-stage piecewise-linear m1->m2 remap with runtime-loaded tables
module remap_sched
  import remap_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  remap_sched_if.slave bus
);
  state_t state_q, state_d;
  logic [M1_W-1:0] node_q [NODE_NUM];
  logic [M1_W-1:0] intc_q [PIECE_NUM];
  logic s1_v_q, s1_oor_q;
  logic [M1_W-1:0] s1_m1_q;
  logic [ID_W-1:0] s1_id_q;
  logic [PW-1:0] s1_p_q, p_d;
  seg_t s1_seg_q;
  logic rsp_valid_q, rsp_oor_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [M2_W-1:0] rsp_m2_q;
  logic s1_adv, s2_adv, issue_en, hit;
  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_idx;
  logic [M1_W-1:0] m1_sel, sum;
  assign s2_adv = !rsp_valid_q || bus.rsp_ready;
  assign s1_adv = !s1_v_q || s2_adv;
  assign issue_en = state_q == ST_RUN && s1_adv;
  assign m1_sel = bus.req_m1[int'(gnt_idx)*M1_W +: M1_W];
  assign sum = s1_m1_q + (s1_oor_q ? '0 : adder_of(s1_seg_q, s1_m1_q) + intc_q[s1_p_q]);
  assign bus.cfg_ready = state_q == ST_CFG;
  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_m2 = rsp_m2_q;
  assign bus.rsp_oor = rsp_oor_q;
  remap_rr_arb u_arb (
    .clk(clk),
    .rst(rst),
    .en_i(issue_en),
    .valid_i(bus.req_valid),
    .gnt_o(gnt),
    .idx_o(gnt_idx)
  );
  // CFG until tables are committed, DRAIN lets in-flight work finish before reopening config
  always_comb begin
    state_d = state_q;
    state_d = state_q == ST_CFG ? (bus.cfg_done ? ST_RUN : ST_CFG)
            : state_q == ST_RUN ? (bus.cfg_req ? ST_DRAIN : ST_RUN)
            : (!s1_v_q && !rsp_valid_q) ? ST_CFG : ST_DRAIN;
  end
  // FSM state register
  always_ff @(posedge clk)
    if (rst) state_q <= ST_CFG;
    else state_q <= state_d;
  // table writes only in CFG; contents deliberately survive reset
  always_ff @(posedge clk)
    if (bus.cfg_ready && bus.cfg_we)
      if (!bus.cfg_sel && int'(bus.cfg_addr) < NODE_NUM) node_q[bus.cfg_addr] <= bus.cfg_data;
      else if (bus.cfg_sel && int'(bus.cfg_addr) < PIECE_NUM) intc_q[bus.cfg_addr] <= bus.cfg_data;
  // piece search runs high to low so the lowest matching piece is the one kept
  always_comb begin
    p_d = '0;
    hit = 1'b0;
    for (int i = PIECE_NUM - 1; i >= 0; i--)
      if (node_q[i] < m1_sel && m1_sel <= node_q[i+1]) begin
        p_d = PW'(i);
        hit = 1'b1;
      end
  end
  // S1: capture the granted operand with its piece, segment and range flag
  always_ff @(posedge clk)
    if (rst) s1_v_q <= 1'b0;
    else if (s1_adv) begin
      s1_v_q <= |gnt;
      s1_m1_q <= m1_sel;
      s1_id_q <= gnt_idx;
      s1_p_q <= p_d;
      s1_oor_q <= !hit;
      s1_seg_q <= seg_of(p_d);
    end
  // S2: sum and drive the response registers, frozen while the consumer stalls
  always_ff @(posedge clk)
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_m2_q <= '0;
      rsp_oor_q <= 1'b0;
    end else if (s2_adv) begin
      rsp_valid_q <= s1_v_q;
      if (s1_v_q) begin
        rsp_id_q <= s1_id_q;
        rsp_m2_q <= M2_W'(sum >> 1);
        rsp_oor_q <= s1_oor_q;
      end
    end
endmodule

// File: tb/tb_remap_sched.sv
// tb_remap_sched: randomized traffic against a queue-based behavioural model plus directed literal checks
module tb_remap_sched;
  import remap_sched_pkg::*;
  typedef struct {
    logic [ID_W-1:0] id;
    logic [M2_W-1:0] m2;
    logic oor;
    int age;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  logic [M1_W-1:0] mnode [NODE_NUM];
  logic [M1_W-1:0] mic [PIECE_NUM];
  ent_t q[$];
  int mstate = 0;
  int mptr = NREQ - 1;
  bit mvalid = 1'b0;
  remap_sched_if bus();
  remap_sched dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // {oor, m2} straight from the remap rules, using the tables the bench has seen written
  function automatic logic [M1_W-1:0] ref_eval(input logic [M1_W-1:0] m1);
    int p;
    longint mm, a, s;
    p = -1;
    mm = longint'(m1);
    for (int i = 0; i < PIECE_NUM; i++)
      if (p < 0 && mnode[i] < m1 && m1 <= mnode[i+1]) p = i;
    if (p < 0) return {1'b1, m1[M1_W-1:1]};
    a = p < 10 ? 4 * mm : p < 22 ? 0 : p < 32 ? -(mm / 8) : -(mm / 4);
    s = (mm + a + longint'(mic[p])) & 64'h7FFFFF;
    return {1'b0, s[M1_W-1:1]};
  endfunction
  // every falling edge: check outputs against the model, then advance the model over the coming edge
  always @(negedge clk) begin : cmp
    int idx, n0;
    bit found, en, rv;
    logic [NREQ-1:0] eg;
    logic [M1_W-1:0] r;
    ent_t e;
    found = 1'b0;
    idx = 0;
    for (int i = 1; i <= NREQ; i++)
      if (!found && bus.req_valid[(mptr + i) % NREQ]) begin
        found = 1'b1;
        idx = (mptr + i) % NREQ;
      end
    en = mstate == 1 && (q.size() < 2 || bus.rsp_ready);
    eg = (en && found) ? NREQ'(1) << idx : '0;
    rv = q.size() > 0 && q[0].age >= 1;
    if (mvalid) begin
      chk("cfg_ready", bus.cfg_ready, mstate == 0);
      chk("req_ready", bus.req_ready, eg);
      chk("rsp_valid", bus.rsp_valid, rv);
      if (rv) begin
        chk("rsp_id", bus.rsp_id, q[0].id);
        chk("rsp_m2", bus.rsp_m2, q[0].m2);
        chk("rsp_oor", bus.rsp_oor, q[0].oor);
      end
    end
    if (rst) begin
      q.delete();
      mstate = 0;
      mptr = NREQ - 1;
      mvalid = 1'b1;
    end else if (mvalid) begin
      n0 = q.size();
      if (mstate == 0 && bus.cfg_we) begin
        if (!bus.cfg_sel && int'(bus.cfg_addr) < NODE_NUM) mnode[bus.cfg_addr] = bus.cfg_data;
        else if (bus.cfg_sel && int'(bus.cfg_addr) < PIECE_NUM) mic[bus.cfg_addr] = bus.cfg_data;
      end
      if (rv && bus.rsp_ready) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (eg != 0) begin
        r = ref_eval(bus.req_m1[idx*M1_W +: M1_W]);
        e.id = ID_W'(idx);
        e.m2 = r[M2_W-1:0];
        e.oor = r[M1_W-1];
        e.age = 0;
        q.push_back(e);
        mptr = idx;
      end
      mstate = mstate == 0 ? (bus.cfg_done ? 1 : 0) : mstate == 1 ? (bus.cfg_req ? 2 : 1) : (n0 == 0 ? 0 : 2);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg_write(input bit sel, input int addr, input logic [M1_W-1:0] d, input bit done);
    bus.cfg_we = 1'b1;
    bus.cfg_sel = sel;
    bus.cfg_addr = AW'(addr);
    bus.cfg_data = d;
    bus.cfg_done = done;
    tick();
    bus.cfg_we = 1'b0;
    bus.cfg_done = 1'b0;
  endtask
  task automatic do_req(input int id, input logic [M1_W-1:0] m1,
                        output logic [M2_W-1:0] m2, output logic oor, output logic [ID_W-1:0] rid);
    int n;
    bus.req_m1[id*M1_W +: M1_W] = m1;
    bus.req_valid = NREQ'(1) << id;
    #1 chk("grant_one", bus.req_ready, NREQ'(1) << id);
    tick();
    bus.req_valid = '0;
    n = 0;
    while (!bus.rsp_valid && n < 8) begin
      tick();
      n++;
    end
    chk("latency", n, 1);
    m2 = bus.rsp_m2;
    oor = bus.rsp_oor;
    rid = bus.rsp_id;
    tick();
  endtask
  task automatic wait_cfg();
    int n;
    n = 0;
    while (!bus.cfg_ready && n < 12) begin
      #1 chk("drain_no_grant", bus.req_ready, 0);
      @(posedge clk);
      #1 n++;
    end
    chk("drain_to_cfg", bus.cfg_ready, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [M2_W-1:0] m2, hold_m2;
    logic [ID_W-1:0] rid, hold_id;
    logic oor;
    logic [M1_W-1:0] v;
    logic [NREQ-1:0] exp_seq [5];
    bus.cfg_req = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_sel = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.cfg_done = 1'b0;
    bus.req_valid = '0;
    bus.req_m1 = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.req_valid = '1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_cfg_ready", bus.cfg_ready, 1);
      chk("rst_no_grant", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_m2", bus.rsp_m2, 0);
      tick();
    end
    bus.req_valid = '0;
    for (int k = 0; k < NODE_NUM; k++) cfg_write(1'b0, k, M1_W'(k << 16), 1'b0);
    cfg_write(1'b0, 50, 23'h7FFFFF, 1'b0);
    cfg_write(1'b1, 42, 23'h7FFFFF, 1'b0);
    for (int k = 0; k < PIECE_NUM; k++) cfg_write(1'b1, k, '0, k == PIECE_NUM - 1);
    chk("model_pin_p0", ref_eval(23'h000800), {1'b0, 22'h001400});
    chk("model_pin_p40", ref_eval(23'h290000), {1'b0, 22'h0F6000});
    chk("model_pin_oor", ref_eval(23'h000000), {1'b1, 22'h000000});
    do_req(0, 23'h000800, m2, oor, rid);
    chk("t2_id", rid, 0);
    chk("t2_m2", m2, 22'h001400);
    chk("t2_oor", oor, 0);
    do_req(0, 23'h290000, m2, oor, rid);
    chk("t3_m2_seg4", m2, 22'h0F6000);
    chk("t3_oor_seg4", oor, 0);
    do_req(0, 23'h000000, m2, oor, rid);
    chk("t3_m2_zero", m2, 22'h000000);
    chk("t3_oor_zero", oor, 1);
    exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    bus.req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < NREQ; k++) bus.req_m1[k*M1_W +: M1_W] = M1_W'($urandom_range(0, 23'h2B0000));
      #1 chk("rr_seq", bus.req_ready, exp_seq[i]);
      tick();
    end
    bus.rsp_ready = 1'b0;
    #1;
    hold_m2 = bus.rsp_m2;
    hold_id = bus.rsp_id;
    for (int i = 0; i < 3; i++) begin
      chk("stall_no_grant", bus.req_ready, 0);
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_m2", bus.rsp_m2, hold_m2);
      chk("stall_id", bus.rsp_id, hold_id);
      @(posedge clk);
      #2;
    end
    bus.rsp_ready = 1'b1;
    repeat (4) tick();
    bus.cfg_req = 1'b1;
    tick();
    wait_cfg();
    bus.cfg_req = 1'b0;
    bus.req_valid = '0;
    cfg_write(1'b1, 0, 23'h000010, 1'b1);
    do_req(0, 23'h000800, m2, oor, rid);
    chk("t6_m2", m2, 22'h001408);
    do_req(2, 23'h2A0000, m2, oor, rid);
    chk("top_node_id", rid, 2);
    chk("top_node_m2", m2, 22'h0FC000);
    chk("top_node_oor", oor, 0);
    do_req(3, 23'h2A0001, m2, oor, rid);
    chk("above_top_m2", m2, 22'h150000);
    chk("above_top_oor", oor, 1);
    bus.cfg_req = 1'b1;
    tick();
    wait_cfg();
    bus.cfg_req = 1'b0;
    v = M1_W'($urandom_range(0, 16'h1000));
    for (int k = 0; k < NODE_NUM; k++) begin
      cfg_write(1'b0, k, v, 1'b0);
      v = v + M1_W'($urandom_range(1, 20'h30000));
    end
    for (int k = 0; k < PIECE_NUM; k++) cfg_write(1'b1, k, M1_W'($urandom), k == PIECE_NUM - 1);
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        int s, j;
        s = $urandom_range(0, 3);
        j = $urandom_range(0, NODE_NUM - 1);
        v = s == 0 ? mnode[j] : s == 1 ? mnode[j] + 1 : s == 2 ? mnode[j] - 1 : M1_W'($urandom);
        bus.req_m1[k*M1_W +: M1_W] = v;
      end
      bus.req_valid = NREQ'($urandom);
      bus.rsp_ready = $urandom_range(0, 9) < 7;
      bus.cfg_we = $urandom_range(0, 15) == 0;
      bus.cfg_sel = 1'($urandom);
      bus.cfg_addr = AW'($urandom);
      bus.cfg_data = M1_W'($urandom);
      bus.cfg_done = $urandom_range(0, 15) == 0;
      tick();
    end
    bus.cfg_we = 1'b0;
    bus.cfg_done = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_cfg_ready", bus.cfg_ready, 1);
    chk("midrst_no_grant", bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
